dlsc_cpu1_icache_fill: RTL

DLSC_CPU1_ICACHE_FILL -- requirements
Module: dlsc_cpu1_icache_fill

---
 rtl/dlsc_cpu1_icache_pkg.sv | 21 ++
 rtl/dlsc_cpu1_icache_fill.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/dlsc_cpu1_icache_pkg.sv
// Shared definitions for the instruction-cache fill engine and cache way:
// fill FSM encodings plus the tag layout (valid bit on top of the upper address bits).
package dlsc_cpu1_icache_pkg;

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_IDLE = 2'd1,
        ST_CMD  = 2'd2,
        ST_FILL = 2'd3
    } fill_state_t;

    // Tag is {valid, addr[ADDR-1:SIZE]}
    function automatic int tag_width(input int addr, input int size);
        return addr - size + 1;
    endfunction

    function automatic int tag_valid_bit(input int addr, input int size);
        return addr - size;
    endfunction

endpackage

// File: rtl/dlsc_cpu1_icache_fill.sv
// Instruction-cache line fill engine: invalidates all tags after reset or flush,
// then services one miss at a time by bursting a whole line into the cache way.
module dlsc_cpu1_icache_fill
    import dlsc_cpu1_icache_pkg::*;
#(
    parameter int  SIZE = 9,
    parameter int  LINE = 4,
    parameter int  DATA = 32,
    parameter int  ADDR = 30,
    localparam int TAG  = tag_width(ADDR, SIZE)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              miss_valid,
    output logic              miss_ready,
    input  logic [ADDR-1:0]   miss_addr,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    output logic [ADDR-1:0]   cmd_addr,
    output logic [LINE-1:0]   cmd_len,
    input  logic              rsp_valid,
    input  logic [DATA-1:0]   rsp_data,
    output logic [SIZE-1:0]   wr_addr,
    output logic              wr_en,
    output logic [DATA-1:0]   wr_data,
    output logic              wr_en_tag,
    output logic [TAG-1:0]    wr_tag,
    output logic              init_done,
    output logic              fill_done
);

    localparam int IDX       = SIZE - LINE;
    localparam int TAG_VALID = tag_valid_bit(ADDR, SIZE);
    localparam logic [IDX-1:0]  IDX_LAST = {IDX{1'b1}};
    localparam logic [LINE-1:0] CNT_LAST = {LINE{1'b1}};

    fill_state_t             r_state;
    fill_state_t             w_state_nx;
    logic [IDX-1:0]          r_index;
    logic                    r_init_done;
    logic                    r_flush_pend;
    logic [ADDR-LINE-1:0]    r_miss_line;
    logic [LINE-1:0]         r_count;
    logic                    r_wr_en;
    logic                    r_wr_last;
    logic [LINE-1:0]         r_wr_off;
    logic [DATA-1:0]         r_wr_data;
    logic                    w_miss_ready;
    logic [TAG-1:0]          w_tag_fill;
    logic                    w_unused;

    // Fills always start at offset 0, so the word offset within the line is never needed
    assign w_unused     = ^miss_addr[LINE-1:0];
    assign w_miss_ready = (r_state == ST_IDLE) && r_init_done && !flush && !r_flush_pend;

    // State register and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_INIT;
            r_index      <= {IDX{1'b0}};
            r_init_done  <= 1'b0;
            r_flush_pend <= 1'b0;
            r_miss_line  <= {(ADDR-LINE){1'b0}};
            r_count      <= {LINE{1'b0}};
            r_wr_en      <= 1'b0;
            r_wr_last    <= 1'b0;
            r_wr_off     <= {LINE{1'b0}};
            r_wr_data    <= {DATA{1'b0}};
        end else begin
            r_state   <= w_state_nx;
            r_wr_en   <= 1'b0;
            r_wr_last <= 1'b0;
            case (r_state)
                ST_INIT: begin
                    r_index <= flush ? {IDX{1'b0}} : (r_index + {{(IDX-1){1'b0}}, 1'b1});
                    if (w_state_nx == ST_IDLE) r_init_done <= 1'b1;
                end
                ST_IDLE: begin
                    if (w_state_nx == ST_INIT) begin
                        r_index      <= {IDX{1'b0}};
                        r_init_done  <= 1'b0;
                        r_flush_pend <= 1'b0;
                    end else if (w_state_nx == ST_CMD) begin
                        r_miss_line  <= miss_addr[ADDR-1:LINE];
                    end
                end
                ST_CMD: begin
                    if (flush) r_flush_pend <= 1'b1;
                    r_count <= {LINE{1'b0}};
                end
                ST_FILL: begin
                    if (flush) r_flush_pend <= 1'b1;
                    if (rsp_valid) begin
                        r_wr_en   <= 1'b1;
                        r_wr_data <= rsp_data;
                        r_wr_off  <= r_count;
                        r_wr_last <= (r_count == CNT_LAST);
                        r_count   <= r_count + {{(LINE-1){1'b0}}, 1'b1};
                    end
                end
                default: r_state <= ST_INIT;
            endcase
        end
    end

    // Next-state logic; flush outranks a simultaneous miss in IDLE
    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            ST_INIT: begin
                if (!flush && r_index == IDX_LAST) w_state_nx = ST_IDLE;
                else                               w_state_nx = ST_INIT;
            end
            ST_IDLE: begin
                if (flush || r_flush_pend)            w_state_nx = ST_INIT;
                else if (miss_valid && w_miss_ready)  w_state_nx = ST_CMD;
                else                                  w_state_nx = ST_IDLE;
            end
            ST_CMD: begin
                if (cmd_ready) w_state_nx = ST_FILL;
                else           w_state_nx = ST_CMD;
            end
            ST_FILL: begin
                if (rsp_valid && r_count == CNT_LAST) w_state_nx = ST_IDLE;
                else                                  w_state_nx = ST_FILL;
            end
            default: w_state_nx = ST_INIT;
        endcase
    end

    // Completed-line tag: valid bit set above the upper address bits
    always_comb begin
        w_tag_fill                 = {TAG{1'b0}};
        w_tag_fill[TAG_VALID]      = 1'b1;
        w_tag_fill[TAG_VALID-1:0]  = r_miss_line[ADDR-LINE-1:SIZE-LINE];
    end

    // Output decode from registered state
    always_comb begin
        miss_ready = w_miss_ready;
        cmd_valid  = (r_state == ST_CMD);
        cmd_addr   = {r_miss_line, {LINE{1'b0}}};
        cmd_len    = CNT_LAST;
        wr_en      = r_wr_en;
        wr_data    = r_wr_data;
        wr_en_tag  = 1'b0;
        wr_tag     = {TAG{1'b0}};
        wr_addr    = {r_miss_line[IDX-1:0], r_wr_off};
        init_done  = r_init_done;
        fill_done  = r_wr_last;
        case (r_state)
            ST_INIT: begin
                wr_en_tag = 1'b1;
                wr_addr   = {r_index, {LINE{1'b0}}};
            end
            ST_CMD: begin
                wr_en_tag = 1'b1;
                wr_addr   = {r_miss_line[IDX-1:0], {LINE{1'b0}}};
            end
            default: begin
                if (r_wr_last) begin
                    wr_en_tag = 1'b1;
                    wr_tag    = w_tag_fill;
                end else begin
                    wr_en_tag = 1'b0;
                end
            end
        endcase
    end

endmodule
